rx_module: RTL
==============

// Module: rx_module
// PURPOSE
//   UART receive path: recovers characters from the external uart_rx_i line using
//   16x oversampling on the shared baud_en_i tick. Frame format matches the Tx side:
//   start, 5-8 data bits LSB first, optional even parity, 1-4 stop bits. Presents
//   received data, a one-cycle done pulse and parity/framing error flags to the
//   UART top/register block.
// PARAMETERS
//   MAX_UART_DATA_W     8  maximum data bits per character
//   STOP_CONF_WIDTH     2  width of stop-bit configuration field
//   DATA_CONF_WIDTH     2  width of data-bit configuration field
//   SAMPLE_COUNT_WIDTH  4  oversample counter width (16 samples per symbol)
//   TOTAL_CONF_WIDTH    5  width of rx_conf_i
// PORTS
//   clk_i         in   1                 top clock
//   rst_i         in   1                 synchronous active-high reset
//   baud_en_i     in   1                 oversample tick (16 per bit period)
//   rx_en_i       in   1                 Rx module enable
//   rx_conf_i     in   TOTAL_CONF_WIDTH  {data[1:0], stop[1:0], parity_en}
//   uart_rx_i     in   1                 external asynchronous UART Rx line
//   rx_data_o     out  MAX_UART_DATA_W   last received char, zero-extended above data width
//   rx_done_o     out  1                 1-clk pulse: character complete
//   rx_busy_o     out  1                 high from valid start to Done
//   parity_err_o  out  1                 parity mismatch on last char (valid with done)
//   frame_err_o   out  1                 a stop bit sampled low on last char
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=Reset, counters 0; 2-flop synchroniser regs reset to 1.
//     Reset mid-frame aborts immediately; no done pulse; partial data discarded.
//   - uart_rx_i passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//   - FSM advances only on baud_en_i cycles. States/transitions:
//     Reset->Idle      rx_en_i=1 and rx_s=1 (never join a frame mid-stream)
//     Idle->RecvStart  rx_s=0; sample counter cleared; conf latched from rx_conf_i
//     RecvStart        at count 7: rx_s=1 -> Idle (glitch, no flags); else continue;
//                      at count 15 -> RecvData, rx_busy_o<=1 set at count 7 valid start
//     RecvData         sample rx_s at count 7 into bit[data_cnt]; at 15 advance
//                      data_cnt; after bit data_cnt_max -> RecvParity if parity_en else RecvStop
//     RecvParity       sample at count 7; at 15 -> RecvStop
//     RecvStop         sample at count 7; rx_s=0 sets frame error; at count 7 of last
//                      stop bit -> Done (early exit so next start edge is not missed)
//     Done (1 tick)    -> Idle if rx_en_i else Reset
//   - Counter wraps 15->0; data_cnt_max = 4 + conf[4:3] (5..8 bits); stops = conf[2:1]+1.
//   - Parity even: parity_err = (received parity bit != ^data bits); 0 if parity disabled.
//   - On entry to Done: rx_data_o, parity_err_o, frame_err_o updated together and
//     rx_done_o high exactly one clk cycle; rx_busy_o cleared same cycle. Outputs
//     hold until next completed character.
//   - rx_en_i deasserted mid-frame: frame completes normally, then FSM -> Reset.
//   - rx_conf_i changes mid-frame have no effect on the current frame.
//   - Latency: done pulse 2 clk (sync) + 1 after last stop-bit mid sample tick.
// TESTING
//   1 8N1, baud_en every 4 clk, send 0xA5 -> rx_data_o=0xA5, 1 done pulse, errs=0.
//   2 5E2 (conf=5'b00011), send 0x13 correct parity -> rx_data_o=0x13, parity_err=0;
//     flip parity bit -> rx_data_o=0x13, parity_err_o=1.
//   3 8N1, stop bit driven 0 for char 0x3C -> rx_data_o=0x3C, frame_err_o=1, done=1.
//   4 Low glitch of 4 ticks on idle line -> FSM back to Idle, no busy, no done.
//   5 Back-to-back 0x55,0xAA zero gap at 8N1 -> two done pulses, both values correct.
//   6 rst_i asserted during data bit 3 -> outputs 0 next cycle; following 0x7E
//     frame received correctly.

Source files
------------

// File: rtl/rx_module.sv
// rx_module -- UART receive path with 16x oversampling.
//
// Recovers characters from the asynchronous uart_rx_i line. Each symbol spans
// 16 baud_en_i ticks; bits are sampled on the 8th tick (count 7). The frame is
// start, 5..8 data bits LSB first, optional even parity, 1..4 stop bits.
//
// Ports
//   clk_i         top clock
//   rst_i         synchronous active-high reset
//   baud_en_i     oversample tick, 16 per bit period
//   rx_en_i       receiver enable
//   rx_conf_i     {data[1:0], stop[1:0], parity_en}
//   uart_rx_i     external asynchronous Rx line
//   rx_data_o     last received character, zero-extended above the data width
//   rx_done_o     one-clock pulse when a character completes
//   rx_busy_o     high from a validated start bit until completion
//   parity_err_o  parity mismatch on the last character
//   frame_err_o   a stop bit of the last character was sampled low
module rx_module #(
  parameter int MAX_UART_DATA_W    = 8,
  parameter int STOP_CONF_WIDTH    = 2,
  parameter int DATA_CONF_WIDTH    = 2,
  parameter int SAMPLE_COUNT_WIDTH = 4,
  parameter int TOTAL_CONF_WIDTH   = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        baud_en_i,
  input  logic                        rx_en_i,
  input  logic [TOTAL_CONF_WIDTH-1:0] rx_conf_i,
  input  logic                        uart_rx_i,
  output logic [MAX_UART_DATA_W-1:0]  rx_data_o,
  output logic                        rx_done_o,
  output logic                        rx_busy_o,
  output logic                        parity_err_o,
  output logic                        frame_err_o
);

  localparam int DCNT_W = $clog2(MAX_UART_DATA_W);
  localparam logic [SAMPLE_COUNT_WIDTH-1:0] MID_CNT  = SAMPLE_COUNT_WIDTH'((1 << SAMPLE_COUNT_WIDTH) / 2 - 1);
  localparam logic [SAMPLE_COUNT_WIDTH-1:0] LAST_CNT = '1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t                        state;
  logic                          rx_meta;
  logic                          rx_s;
  logic [SAMPLE_COUNT_WIDTH-1:0] sample_cnt;
  logic [DCNT_W-1:0]             data_cnt;
  logic [DCNT_W-1:0]             data_cnt_max;
  logic [STOP_CONF_WIDTH-1:0]    stop_cnt;
  logic [STOP_CONF_WIDTH-1:0]    stop_max;
  logic                          parity_en;
  logic                          frame_flag;
  logic [MAX_UART_DATA_W-1:0]    data_buf;
  logic                          par_bit;

  logic mid_tick;
  logic last_tick;
  assign mid_tick  = (sample_cnt == MID_CNT);
  assign last_tick = (sample_cnt == LAST_CNT);

  // Unused upper data bits stay zero, so they do not disturb the parity.
  function automatic logic even_parity(input logic [MAX_UART_DATA_W-1:0] d);
    return ^d;
  endfunction

  // Control path: synchroniser, FSM, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= ST_RESET;
      sample_cnt   <= '0;
      data_cnt     <= '0;
      data_cnt_max <= '0;
      stop_cnt     <= '0;
      stop_max     <= '0;
      parity_en    <= 1'b0;
      frame_flag   <= 1'b0;
      rx_data_o    <= '0;
      rx_done_o    <= 1'b0;
      rx_busy_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_meta   <= uart_rx_i;
      rx_s      <= rx_meta;
      rx_done_o <= 1'b0;
      if (baud_en_i) begin
        case (state)
          // Only leave Reset on an idle (high) line so a frame in flight is never joined.
          ST_RESET: if (rx_en_i && rx_s) state <= ST_IDLE;
          ST_IDLE: begin
            if (!rx_en_i) begin
              state <= ST_RESET;
            end else if (!rx_s) begin
              state        <= ST_START;
              sample_cnt   <= '0;
              data_cnt     <= '0;
              stop_cnt     <= '0;
              frame_flag   <= 1'b0;
              // Configuration is frozen for the whole frame.
              data_cnt_max <= DCNT_W'(4) + DCNT_W'(rx_conf_i[TOTAL_CONF_WIDTH-1 -: DATA_CONF_WIDTH]);
              stop_max     <= rx_conf_i[STOP_CONF_WIDTH:1];
              parity_en    <= rx_conf_i[0];
            end
          end
          ST_START: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (mid_tick) begin
              if (rx_s) state <= ST_IDLE;  // glitch, not a real start bit
              else      rx_busy_o <= 1'b1;
            end else if (last_tick) begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (last_tick) begin
              if (data_cnt == data_cnt_max) state <= parity_en ? ST_PARITY : ST_STOP;
              else                          data_cnt <= data_cnt + 1'b1;
            end
          end
          ST_PARITY: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (last_tick) state <= ST_STOP;
          end
          ST_STOP: begin
            sample_cnt <= sample_cnt + 1'b1;
            if (mid_tick) begin
              // Finish at the middle of the last stop bit so the next start edge is caught.
              if (stop_cnt == stop_max) begin
                state        <= ST_DONE;
                rx_data_o    <= data_buf;
                parity_err_o <= parity_en & (par_bit != even_parity(data_buf));
                frame_err_o  <= frame_flag | ~rx_s;
                rx_done_o    <= 1'b1;
                rx_busy_o    <= 1'b0;
              end else if (!rx_s) begin
                frame_flag <= 1'b1;
              end
            end
            if (last_tick) stop_cnt <= stop_cnt + 1'b1;
          end
          ST_DONE: state <= rx_en_i ? ST_IDLE : ST_RESET;
          default: state <= ST_RESET;
        endcase
      end
    end
  end

  // Data path: bit capture, no reset needed since it is cleared at each start.
  always_ff @(posedge clk_i) begin
    if (baud_en_i) begin
      if (state == ST_IDLE && rx_en_i && !rx_s) begin
        data_buf <= '0;
        par_bit  <= 1'b0;
      end else if (state == ST_DATA && mid_tick) begin
        data_buf[data_cnt] <= rx_s;
      end else if (state == ST_PARITY && mid_tick) begin
        par_bit <= rx_s;
      end
    end
  end

endmodule
